// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit, one shift-add or
// restoring-subtract step per cycle, with a destination tag for writeback.
module muldiv_sequencer #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] rd_out,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [TAG_W-1:0] rd_q, rd_d;
    logic [TAG_W-1:0] rd_out_q, rd_out_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [W2-1:0]    step;

    // acc holds {hi,lo} for MUL and {remainder,quotient} for DIV,
    // so the final select is the same for both: op[0] picks the upper half.
    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[W2-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd_q};
        if (op_q[1]) begin
            if (diff[WIDTH]) begin
                step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    assign accept = start & ~flush & ~rst
                  & (state_q == S_IDLE || state_q == S_DONE);

    // Next-state, iteration and result capture; a new issue overrides
    // the DONE->IDLE return so back-to-back ops lose no cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        unique case (state_q)
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = step;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_d  = S_DONE;
                        rd_out_d = rd_q;
                        result_d = op_q[0] ? step[W2-1:WIDTH]
                                           : step[WIDTH-1:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_RUN;
            count_d = '0;
            op_d    = op;
            rd_d    = rd_in;
            opnd_d  = op[1] ? src_b : src_a;
            acc_d   = {{WIDTH{1'b0}}, (op[1] ? src_a : src_b)};
            dbz_d   = op[1] & (src_b == '0);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = accept | (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign rd_out      = rd_out_q;
    assign div_by_zero = done & dbz_q;

endmodule
